// File: rtl/seg_pkg.sv
// Shared active-low 7-segment pattern table (g..a order) and digit code constants.
// The forward display driver and the capture monitor both decode through this table.
package seg_pkg;
  localparam logic [6:0] SEG_PAT_0 = 7'b1000000;
  localparam logic [6:0] SEG_PAT_1 = 7'b1111001;
  localparam logic [6:0] SEG_PAT_2 = 7'b0100100;
  localparam logic [6:0] SEG_PAT_3 = 7'b0110000;
  localparam logic [6:0] SEG_PAT_4 = 7'b0011001;
  localparam logic [6:0] SEG_PAT_5 = 7'b0010010;
  localparam logic [6:0] SEG_PAT_6 = 7'b0000010;
  localparam logic [6:0] SEG_PAT_7 = 7'b1111000;
  localparam logic [6:0] SEG_PAT_8 = 7'b0000000;
  localparam logic [6:0] SEG_PAT_9 = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] CODE_BLANK = 4'hF;
endpackage

// File: rtl/seg_pattern_decode.sv
// Inverse segment decode: active-low g..a pattern to a digit code, flagging unknown patterns.
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] pat,
  output logic       known,
  output logic [3:0] code
);
  always_comb begin
    known = 1'b1;
    code  = CODE_BLANK;
    case (pat)
      SEG_PAT_0: code = 4'd0;
      SEG_PAT_1: code = 4'd1;
      SEG_PAT_2: code = 4'd2;
      SEG_PAT_3: code = 4'd3;
      SEG_PAT_4: code = 4'd4;
      SEG_PAT_5: code = 4'd5;
      SEG_PAT_6: code = 4'd6;
      SEG_PAT_7: code = 4'd7;
      SEG_PAT_8: code = 4'd8;
      SEG_PAT_9: code = 4'd9;
      SEG_BLANK: code = CODE_BLANK;
      default:   known = 1'b0;
    endcase
  end
endmodule

// File: rtl/seg_scan_capture.sv
// Monitors a multiplexed active-low 7-segment bus, waits for each anode/segment pattern
// to settle, then decodes it back into a per-position captured frame.
module seg_scan_capture
  import seg_pkg::*;
#(
  parameter int NDIG   = 8,
  parameter int STABLE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NDIG-1:0]   an,
  input  logic [7:0]        seg,
  input  logic              clear,
  output logic [4*NDIG-1:0] digits,
  output logic [NDIG-1:0]   dp,
  output logic [NDIG-1:0]   valid,
  output logic [NDIG-1:0]   pat_err,
  output logic              multi_err,
  output logic              frame_done
);
  localparam int CW = $clog2(STABLE + 1);
  localparam logic [CW-1:0] CNT_SAT  = CW'(STABLE);
  localparam logic [CW-1:0] CNT_FIRE = CW'(STABLE - 1);

  logic [NDIG-1:0] s_an, p_an, sel, hit_vec, valid_next;
  logic [7:0]      s_seg, p_seg;
  logic [CW-1:0]   cnt, cnt_next;
  logic            wipe, fire, none, one_hot, known;
  logic [3:0]      code;

  assign wipe = !rst_n || clear;

  // Counter saturates one above the fire point so a held pattern never refires.
  always_comb begin
    if ({s_an, s_seg} != {p_an, p_seg}) cnt_next = '0;
    else if (cnt == CNT_SAT)             cnt_next = cnt;
    else                                 cnt_next = cnt + CW'(1);
  end

  assign fire    = (cnt_next == CNT_FIRE);
  assign sel     = ~s_an;
  assign none    = (sel == '0);
  assign one_hot = !none && ((sel & (sel - NDIG'(1))) == '0);
  assign hit_vec = (fire && one_hot) ? sel : '0;
  assign valid_next = valid | hit_vec;

  seg_pattern_decode u_dec (
    .pat   (s_seg[6:0]),
    .known (known),
    .code  (code)
  );

  // Clear also flushes the sample pipeline so a held pattern restarts its settle window.
  always_ff @(posedge clk) begin
    if (wipe) begin
      s_an       <= '1;
      s_seg      <= '1;
      p_an       <= '1;
      p_seg      <= '1;
      cnt        <= '0;
      multi_err  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      p_an       <= s_an;
      p_seg      <= s_seg;
      s_an       <= an;
      s_seg      <= seg;
      cnt        <= cnt_next;
      multi_err  <= multi_err | (fire && !none && !one_hot);
      frame_done <= (valid != '1) && (valid_next == '1);
    end
  end

  for (genvar i = 0; i < NDIG; i++) begin : g_pos
    logic [3:0] dig_q;
    logic       dp_q, vld_q, perr_q;

    always_ff @(posedge clk) begin
      if (wipe) begin
        dig_q  <= '0;
        dp_q   <= 1'b0;
        vld_q  <= 1'b0;
        perr_q <= 1'b0;
      end else if (hit_vec[i]) begin
        dig_q  <= known ? code : CODE_BLANK;
        dp_q   <= ~s_seg[7];
        vld_q  <= 1'b1;
        perr_q <= ~known;
      end
    end

    assign digits[4*i +: 4] = dig_q;
    assign dp[i]            = dp_q;
    assign valid[i]         = vld_q;
    assign pat_err[i]       = perr_q;
  end
endmodule

// File: tb/tb_seg_scan_capture.sv
// Self-checking bench for seg_scan_capture: directed scenarios plus randomized bus traffic
// compared every cycle against a sample-history reference model.
module tb_seg_scan_capture;
  localparam int NDIG = 8, STABLE = 4;

  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
  logic [NDIG-1:0] an = '1;
  logic [7:0] seg = '1;
  logic [4*NDIG-1:0] digits;
  logic [NDIG-1:0] dp, valid, pat_err;
  logic multi_err, frame_done;
  int n_checks = 0, n_pass = 0;

  always #5 clk = ~clk;

  seg_scan_capture #(.NDIG(NDIG), .STABLE(STABLE)) dut (
    .clk(clk), .rst_n(rst_n), .an(an), .seg(seg), .clear(clear),
    .digits(digits), .dp(dp), .valid(valid), .pat_err(pat_err),
    .multi_err(multi_err), .frame_done(frame_done)
  );

  // Digit table 0..9 then blank, active-low g..a.
  logic [6:0] tbl [11] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10, 7'h7F};

  // Reference model: a pattern is captured once it has been sampled STABLE times in a row.
  logic [4*NDIG-1:0] m_dig = '0;
  logic [NDIG-1:0] m_dp = '0, m_valid = '0, m_perr = '0;
  logic m_merr = 1'b0, m_fd = 1'b0;
  logic [NDIG+7:0] hist[$];

  always @(posedge clk) begin
    logic fire, known;
    logic [NDIG+7:0] cur;
    logic [NDIG-1:0] cur_an, t_dp, t_valid, t_perr;
    logic [4*NDIG-1:0] t_dig;
    logic [3:0] code;
    logic t_merr;
    int last, pos;
    if (!rst_n || clear) begin
      hist.delete();
      m_dig <= '0; m_dp <= '0; m_valid <= '0; m_perr <= '0; m_merr <= 1'b0; m_fd <= 1'b0;
    end else begin
      t_dig = m_dig; t_dp = m_dp; t_valid = m_valid; t_perr = m_perr; t_merr = m_merr;
      fire = 1'b0;
      last = hist.size() - 1;
      if (hist.size() >= STABLE) begin
        fire = 1'b1;
        for (int k = 1; k < STABLE; k++) if (hist[last-k] != hist[last]) fire = 1'b0;
        if (hist.size() > STABLE && hist[last-STABLE] == hist[last]) fire = 1'b0;
      end
      if (fire) begin
        cur = hist[last];
        cur_an = cur[NDIG+7:8];
        if ($countones(~cur_an) > 1) t_merr = 1'b1;
        else if ($countones(~cur_an) == 1) begin
          pos = 0;
          for (int k = 0; k < NDIG; k++) if (!cur_an[k]) pos = k;
          known = 1'b0; code = 4'hF;
          for (int d = 0; d < 11; d++)
            if (tbl[d] == cur[6:0]) begin known = 1'b1; code = (d == 10) ? 4'hF : 4'(d); end
          t_dig[4*pos +: 4] = code;
          t_dp[pos] = ~cur[7];
          t_valid[pos] = 1'b1;
          t_perr[pos] = ~known;
        end
      end
      hist.push_back({an, seg});
      if (hist.size() > STABLE + 1) void'(hist.pop_front());
      m_fd <= (m_valid != '1) && (t_valid == '1);
      m_dig <= t_dig; m_dp <= t_dp; m_valid <= t_valid; m_perr <= t_perr; m_merr <= t_merr;
    end
  end

  wire [4*NDIG+3*NDIG+1:0] dut_all = {digits, dp, valid, pat_err, multi_err, frame_done};
  wire [4*NDIG+3*NDIG+1:0] exp_all = {m_dig, m_dp, m_valid, m_perr, m_merr, m_fd};

  // Advance one clock; returns at the following negedge where outputs are sampled.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; clear = 1'b0; an = '1; seg = '1;
    cyc(); cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; an = 8'hFE; seg = 8'h79;
    cyc(); cyc();
    n_checks++;
    if (dut_all !== '0) $display("FAIL reset_state: got %h want 0", dut_all); else n_pass++;
    rst_n = 1'b1; an = '1; seg = '1;
  endtask

  task automatic test_single_capture();
    do_reset();
    an = 8'hFE; seg = 8'hC0;
    for (int c = 1; c <= 6; c++) begin
      cyc();
      if (c == 4) begin
        n_checks++;
        if (valid !== 8'h00) $display("FAIL cap_latency_early: valid %h want 00", valid); else n_pass++;
      end
      if (c == 5) begin
        n_checks++;
        if ({digits[3:0], valid, dp[0]} !== {4'h0, 8'h01, 1'b0})
          $display("FAIL cap_digit0: dig %h valid %h dp %b want 0/01/0", digits[3:0], valid, dp[0]);
        else n_pass++;
      end
      n_checks++;
      if (dut_all !== exp_all) $display("FAIL cap_model c%0d: got %h want %h", c, dut_all, exp_all); else n_pass++;
    end
  endtask

  task automatic test_scan_frame();
    int pulses;
    do_reset();
    for (int round = 0; round < 3; round++) begin
      if (round == 2) begin
        clear = 1'b1; cyc(); clear = 1'b0;
        n_checks++;
        if (dut_all !== '0) $display("FAIL scan_clear: got %h want 0", dut_all); else n_pass++;
      end
      if (round != 1) pulses = 0;
      for (int p = 0; p < NDIG; p++) begin
        an = ~(NDIG'(1) << p);
        seg = {1'b1, tbl[p+1]};
        for (int c = 0; c < 8; c++) begin
          cyc();
          if (frame_done) pulses++;
          n_checks++;
          if (dut_all !== exp_all) $display("FAIL scan_model r%0d p%0d: got %h want %h", round, p, dut_all, exp_all);
          else n_pass++;
        end
      end
      if (round != 0) begin
        n_checks++;
        if ({digits, valid, pulses} !== {32'h87654321, 8'hFF, 32'd1})
          $display("FAIL scan_frame r%0d: digits %h valid %h pulses %0d want 87654321/ff/1", round, digits, valid, pulses);
        else n_pass++;
      end
    end
  endtask

  task automatic test_pattern_error();
    do_reset();
    an = 8'hFD; seg = 8'h55;
    repeat (6) cyc();
    n_checks++;
    if ({digits[7:4], pat_err[1], valid[1]} !== {4'hF, 1'b1, 1'b1})
      $display("FAIL perr_set: dig %h perr %b valid %b want f/1/1", digits[7:4], pat_err[1], valid[1]);
    else n_pass++;
    seg = 8'h24;
    repeat (6) cyc();
    n_checks++;
    if ({digits[7:4], pat_err[1], dp[1]} !== {4'h2, 1'b0, 1'b1})
      $display("FAIL perr_clear: dig %h perr %b dp %b want 2/0/1", digits[7:4], pat_err[1], dp[1]);
    else n_pass++;
    n_checks++;
    if (dut_all !== exp_all) $display("FAIL perr_model: got %h want %h", dut_all, exp_all); else n_pass++;
  endtask

  task automatic test_multi_and_glitch();
    do_reset();
    an = 8'hFC; seg = 8'hC0;
    repeat (6) cyc();
    n_checks++;
    if ({multi_err, valid} !== {1'b1, 8'h00})
      $display("FAIL multi_err: merr %b valid %h want 1/00", multi_err, valid);
    else n_pass++;
    an = 8'hFE;
    for (int c = 0; c < 20; c++) begin
      seg = (c[1]) ? 8'hF9 : 8'hC0;
      cyc();
      n_checks++;
      if ({valid, multi_err} !== {8'h00, 1'b1} || dut_all !== exp_all)
        $display("FAIL glitch c%0d: got %h want %h", c, dut_all, exp_all);
      else n_pass++;
    end
  endtask

  task automatic test_dp_reset_clear();
    do_reset();
    an = 8'h7F; seg = 8'h40;
    repeat (6) cyc();
    n_checks++;
    if ({dp[7], digits[31:28], valid[7]} !== {1'b1, 4'h0, 1'b1})
      $display("FAIL dp7: dp %b dig %h valid %b want 1/0/1", dp[7], digits[31:28], valid[7]);
    else n_pass++;
    an = 8'hBF; seg = 8'hF9;
    cyc(); cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    n_checks++;
    if (dut_all !== '0) $display("FAIL mid_settle_reset: got %h want 0", dut_all); else n_pass++;
    an = 8'hFE; seg = 8'hA4;
    repeat (4) cyc();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    n_checks++;
    if (dut_all !== '0) $display("FAIL clear_vs_capture: got %h want 0", dut_all); else n_pass++;
    repeat (6) cyc();
    n_checks++;
    if ({digits[3:0], valid} !== {4'h2, 8'h01} || dut_all !== exp_all)
      $display("FAIL after_clear: got %h want %h", dut_all, exp_all);
    else n_pass++;
  endtask

  task automatic test_random();
    int hold, sel;
    do_reset();
    for (int t = 0; t < 300; t++) begin
      sel = $urandom_range(0, 19);
      if (sel < 14)      an = ~(NDIG'(1) << $urandom_range(0, NDIG - 1));
      else if (sel < 17) an = '1;
      else               an = NDIG'($urandom);
      if ($urandom_range(0, 9) < 7) seg = {1'($urandom), tbl[$urandom_range(0, 10)]};
      else                          seg = 8'($urandom);
      hold = $urandom_range(1, 7);
      for (int c = 0; c < hold; c++) begin
        clear = ($urandom_range(0, 39) == 0);
        cyc();
        clear = 1'b0;
        n_checks++;
        if (dut_all !== exp_all) $display("FAIL random t%0d c%0d: got %h want %h", t, c, dut_all, exp_all);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_capture();
    test_scan_frame();
    test_pattern_error();
    test_multi_and_glitch();
    test_dp_reset_clear();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
